regfile_wb_arbiter: RTL and testbench

Write-back arbiter and busy scoreboard for the 32×32 register file. Two write-back sources share the register file's single write port: requester 0 is the ALU result path and requester 1 is the load/memory return path. The block arbitrates between them, registers the winning write onto WE3/A3/WD3, and tracks which registers still have a write outstanding so issue logic can stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the write-back arbiter's handshake, scoreboard and register-file
// write-port signals. The master side is the surrounding pipeline (requesters,
// issue stage and register file); the slave side is the arbiter itself.
interface regfile_wb_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2**ADDR_W
);
   logic              REQ0_VALID;
   logic [ADDR_W-1:0] REQ0_ADDR;
   logic [DATA_W-1:0] REQ0_DATA;
   logic              REQ0_READY;
   logic              REQ1_VALID;
   logic [ADDR_W-1:0] REQ1_ADDR;
   logic [DATA_W-1:0] REQ1_DATA;
   logic              REQ1_READY;
   logic              RSV_VALID;
   logic [ADDR_W-1:0] RSV_ADDR;
   logic [ADDR_W-1:0] QA1;
   logic [ADDR_W-1:0] QA2;
   logic              STALL;
   logic [DEPTH-1:0]  BUSY;
   logic              WE3;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;

   modport master (
      output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
      input  REQ0_READY,
      output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
      input  REQ1_READY,
      output RSV_VALID, RSV_ADDR, QA1, QA2,
      input  STALL, BUSY, WE3, A3, WD3
   );

   modport slave (
      input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
      output REQ0_READY,
      input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
      output REQ1_READY,
      input  RSV_VALID, RSV_ADDR, QA1, QA2,
      output STALL, BUSY, WE3, A3, WD3
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the register file.
// Requester 0 is the ALU result path, requester 1 the load return path.
// The winning write is registered onto WE3/A3/WD3; writes to register 0 are
// accepted but dropped. BUSY tracks registers with a write outstanding.
// Optional feature macro: WBARB_RR_EN selects round-robin arbitration; when
// undefined, port 1 has fixed priority and no LAST pointer exists.
module regfile_wb_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2**ADDR_W
) (
   input logic                 CLK,
   input logic                 RST,
   regfile_wb_arbiter_if.slave bus
);

   logic              gnt0;
   logic              gnt1;
   logic              xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              we3_q;
   logic [ADDR_W-1:0] a3_q;
   logic [DATA_W-1:0] wd3_q;
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_next;

`ifdef WBARB_RR_EN
   logic last_q;  // port granted most recently; 1 after reset so port 0 wins first

   // Round-robin grant: a lone requester wins, contention goes to the port not granted last.
   always_comb begin
      gnt0 = bus.REQ0_VALID & (~bus.REQ1_VALID | last_q);
      gnt1 = bus.REQ1_VALID & (~bus.REQ0_VALID | ~last_q);
   end

   // Remember the last granted port; only a grant moves the pointer.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)      last_q <= 1'b1;
      else if (xfer) last_q <= gnt1;
   end
`else
   // Fixed-priority grant: the load return path always wins contention.
   always_comb begin
      gnt1 = bus.REQ1_VALID;
      gnt0 = bus.REQ0_VALID & ~bus.REQ1_VALID;
   end
`endif

   assign xfer           = gnt0 | gnt1;
   assign bus.REQ0_READY = gnt0;
   assign bus.REQ1_READY = gnt1;

   // Select the granted port's address and data for the output stage.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      sel_addr = bus.REQ0_ADDR;
      sel_data = bus.REQ0_DATA;
      if (gnt1) begin
         sel_addr = bus.REQ1_ADDR;
         sel_data = bus.REQ1_DATA;
      end
   end

   // Next busy vector: clear the register being written, then apply a reservation so a set wins.
   always_comb begin
      busy_next = busy_q;
      if (we3_q)
         busy_next[a3_q] = 1'b0;
      if (bus.RSV_VALID && (bus.RSV_ADDR != '0))
         busy_next[bus.RSV_ADDR] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Register the granted write and the scoreboard; reset discards any in-flight write.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         // NOTE: non-blocking assignments in sequential blocks so every flop samples pre-edge values.
         we3_q  <= 1'b0;
         a3_q   <= '0;
         wd3_q  <= '0;
         // NOTE: the busy flags are plain flops, not a RAM, so they are reset; stale reservations would stall issue forever.
         busy_q <= '0;
      end else begin
         we3_q  <= xfer && (sel_addr != '0);
         busy_q <= busy_next;
         if (xfer) begin
            a3_q  <= sel_addr;
            wd3_q <= sel_data;
         end
      end
   end

   assign bus.WE3   = we3_q;
   assign bus.A3    = a3_q;
   assign bus.WD3   = wd3_q;
   assign bus.BUSY  = busy_q;
   assign bus.STALL = ((bus.QA1 != '0) & busy_q[bus.QA1]) |
                      ((bus.QA2 != '0) & busy_q[bus.QA2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. Expected register-file writes are queued when
// a transfer is driven and checked by a monitor when WE3 is seen; each
// scenario task also checks handshake, scoreboard and stall behaviour inline.
module tb_regfile_wb_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2**ADDR_W;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic CLK;
   logic RST;
   int   n_cmp;
   int   n_bad;
   wr_t  exp_q[$];
   wr_t  mon_e;

   regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Monitor: every register-file write must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (RST === 1'b1 && bus.WE3 === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL wb_unexpected: got A3=%0d WD3=%h, expected no write", bus.A3, bus.WD3);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.A3 !== mon_e.addr || bus.WD3 !== mon_e.data) begin
               n_bad++;
               $display("FAIL wb_data: got A3=%0d WD3=%h, expected A3=%0d WD3=%h",
                        bus.A3, bus.WD3, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.REQ0_VALID = 1'b0;
      bus.REQ0_ADDR  = '0;
      bus.REQ0_DATA  = '0;
      bus.REQ1_VALID = 1'b0;
      bus.REQ1_ADDR  = '0;
      bus.REQ1_DATA  = '0;
      bus.RSV_VALID  = 1'b0;
      bus.RSV_ADDR   = '0;
      bus.QA1        = '0;
      bus.QA2        = '0;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      exp_q.push_back('{addr: addr, data: data});
   endtask

   // Asynchronous reset pulse placed mid-cycle, away from both clock edges.
   task automatic pulse_reset();
      @(posedge CLK);
      #2 RST = 1'b0;
      #2 RST = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] d;
      d = 32'h5555_AAAA;
      @(negedge CLK); #1;
      n_cmp++;
      if (bus.WE3 !== 1'b0 || bus.A3 !== '0 || bus.WD3 !== '0 || bus.BUSY !== '0) begin
         n_bad++;
         $display("FAIL reset_initial: got WE3=%b A3=%0d WD3=%h BUSY=%h, expected all 0",
                  bus.WE3, bus.A3, bus.WD3, bus.BUSY);
      end
      @(posedge CLK); #3 RST = 1'b1;
      @(negedge CLK);
      bus.REQ0_VALID = 1'b1; bus.REQ0_ADDR = 5'd5; bus.REQ0_DATA = d;
      bus.RSV_VALID  = 1'b1; bus.RSV_ADDR  = 5'd5;
      #1;
      n_cmp++;
      if (bus.REQ0_READY !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_ready: got REQ0_READY=%b, expected 1", bus.REQ0_READY);
      end
      push_exp(5'd5, d);
      @(posedge CLK); #2;
      idle_inputs();
      n_cmp++;
      if (bus.WE3 !== 1'b1 || bus.BUSY[5] !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_state: got WE3=%b BUSY5=%b, expected 1 1", bus.WE3, bus.BUSY[5]);
      end
      RST = 1'b0;
      #1;
      n_cmp++;
      if (bus.WE3 !== 1'b0 || bus.A3 !== '0 || bus.WD3 !== '0 || bus.BUSY !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got WE3=%b A3=%0d WD3=%h BUSY=%h, expected all 0",
                  bus.WE3, bus.A3, bus.WD3, bus.BUSY);
      end
      exp_q.delete();
      #1 RST = 1'b1;
      @(negedge CLK);
      bus.QA1 = 5'd5; bus.QA2 = 5'd5;
      #1;
      n_cmp++;
      if (bus.REQ0_READY !== 1'b0 || bus.REQ1_READY !== 1'b0 || bus.STALL !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: got READY0=%b READY1=%b STALL=%b, expected 0 0 0",
                  bus.REQ0_READY, bus.REQ1_READY, bus.STALL);
      end
      idle_inputs();
   endtask

   task automatic test_single_write();
      @(negedge CLK);
      bus.REQ0_VALID = 1'b1; bus.REQ0_ADDR = 5'd7; bus.REQ0_DATA = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if (bus.REQ0_READY !== 1'b1 || bus.REQ1_READY !== 1'b0) begin
         n_bad++;
         $display("FAIL single_ready: got READY0=%b READY1=%b, expected 1 0",
                  bus.REQ0_READY, bus.REQ1_READY);
      end
      push_exp(5'd7, 32'hDEAD_BEEF);
      @(negedge CLK);
      idle_inputs();
      #1;
      n_cmp++;
      if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL single_out: got WE3=%b A3=%0d WD3=%h, expected 1 7 deadbeef",
                  bus.WE3, bus.A3, bus.WD3);
      end
      @(negedge CLK); #1;
      n_cmp++;
      if (bus.WE3 !== 1'b0) begin
         n_bad++;
         $display("FAIL single_we_drop: got WE3=%b, expected 0", bus.WE3);
      end
   endtask

   task automatic test_contention();
      int exp_g;
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         bus.REQ0_VALID = 1'b1; bus.REQ0_ADDR = 5'd1; bus.REQ0_DATA = 32'hA000_0001;
         bus.REQ1_VALID = 1'b1; bus.REQ1_ADDR = 5'd2; bus.REQ1_DATA = 32'hB000_0002;
`ifdef WBARB_RR_EN
         exp_g = i % 2;
`else
         exp_g = 1;
`endif
         #1;
         n_cmp++;
         if (bus.REQ0_READY !== (exp_g == 0) || bus.REQ1_READY !== (exp_g == 1)) begin
            n_bad++;
            $display("FAIL contention_grant%0d: got READY0=%b READY1=%b, expected grant port %0d",
                     i, bus.REQ0_READY, bus.REQ1_READY, exp_g);
         end
         if (exp_g == 1) push_exp(5'd2, 32'hB000_0002);
         else            push_exp(5'd1, 32'hA000_0001);
      end
      @(negedge CLK);
      idle_inputs();
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_scoreboard();
      @(negedge CLK);
      bus.RSV_VALID = 1'b1; bus.RSV_ADDR = 5'd9;
      @(negedge CLK);
      bus.RSV_VALID  = 1'b0;
      bus.QA1        = 5'd9;
      bus.REQ1_VALID = 1'b1; bus.REQ1_ADDR = 5'd9; bus.REQ1_DATA = 32'h9999_0001;
      #1;
      n_cmp++;
      if (bus.BUSY[9] !== 1'b1 || bus.STALL !== 1'b1 || bus.REQ1_READY !== 1'b1) begin
         n_bad++;
         $display("FAIL sb_reserve: got BUSY9=%b STALL=%b READY1=%b, expected 1 1 1",
                  bus.BUSY[9], bus.STALL, bus.REQ1_READY);
      end
      push_exp(5'd9, 32'h9999_0001);
      @(negedge CLK);
      bus.REQ1_VALID = 1'b0;
      #1;
      n_cmp++;
      if (bus.STALL !== 1'b1) begin
         n_bad++;
         $display("FAIL sb_stall_hold: got STALL=%b, expected 1", bus.STALL);
      end
      @(negedge CLK); #1;
      n_cmp++;
      if (bus.STALL !== 1'b0 || bus.BUSY[9] !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_clear: got STALL=%b BUSY9=%b, expected 0 0", bus.STALL, bus.BUSY[9]);
      end
      @(negedge CLK);
      bus.REQ1_VALID = 1'b1; bus.REQ1_ADDR = 5'd9; bus.REQ1_DATA = 32'h9999_0002;
      #1;
      push_exp(5'd9, 32'h9999_0002);
      @(negedge CLK);
      bus.REQ1_VALID = 1'b0;
      bus.RSV_VALID  = 1'b1; bus.RSV_ADDR = 5'd9;
      #1;
      n_cmp++;
      if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd9) begin
         n_bad++;
         $display("FAIL sb_collide_we: got WE3=%b A3=%0d, expected 1 9", bus.WE3, bus.A3);
      end
      @(negedge CLK);
      bus.RSV_VALID = 1'b0;
      #1;
      n_cmp++;
      if (bus.BUSY[9] !== 1'b1 || bus.STALL !== 1'b1) begin
         n_bad++;
         $display("FAIL sb_set_wins: got BUSY9=%b STALL=%b, expected 1 1", bus.BUSY[9], bus.STALL);
      end
      idle_inputs();
   endtask

   task automatic test_reg_zero();
      @(negedge CLK);
      bus.RSV_VALID  = 1'b1; bus.RSV_ADDR  = 5'd0;
      bus.REQ0_VALID = 1'b1; bus.REQ0_ADDR = 5'd0; bus.REQ0_DATA = 32'hFFFF_0000;
      bus.QA1 = 5'd0; bus.QA2 = 5'd0;
      #1;
      n_cmp++;
      if (bus.REQ0_READY !== 1'b1) begin
         n_bad++;
         $display("FAIL r0_ready: got REQ0_READY=%b, expected 1", bus.REQ0_READY);
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      n_cmp++;
      if (bus.WE3 !== 1'b0 || bus.BUSY[0] !== 1'b0 || bus.STALL !== 1'b0) begin
         n_bad++;
         $display("FAIL r0_drop: got WE3=%b BUSY0=%b STALL=%b, expected 0 0 0",
                  bus.WE3, bus.BUSY[0], bus.STALL);
      end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      for (int i = 0; i < 32; i++) begin
         @(negedge CLK);
         a = ADDR_W'((i % 31) + 1);
         d = 32'h1000_0000 + DATA_W'(i);
         bus.REQ0_VALID = 1'b1; bus.REQ0_ADDR = a; bus.REQ0_DATA = d;
         #1;
         n_cmp++;
         if (bus.REQ0_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready%0d: got REQ0_READY=%b, expected 1", i, bus.REQ0_READY);
         end
         push_exp(a, d);
         if (i > 0) begin
            n_cmp++;
            if (bus.WE3 !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_we%0d: got WE3=%b, expected 1", i, bus.WE3);
            end
         end
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      n_cmp++;
      if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd1 || bus.WD3 !== 32'h1000_001F) begin
         n_bad++;
         $display("FAIL b2b_last: got WE3=%b A3=%0d WD3=%h, expected 1 1 1000001f",
                  bus.WE3, bus.A3, bus.WD3);
      end
      @(negedge CLK); #1;
      n_cmp++;
      if (bus.WE3 !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_end: got WE3=%b, expected 0", bus.WE3);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      RST   = 1'b0;
      idle_inputs();
      test_reset();
      test_single_write();
      test_contention();
      test_scoreboard();
      test_reg_zero();
      test_back_to_back();
      repeat (2) @(negedge CLK);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL wb_drain: got %0d writes still pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
